// File: rtl/writeback_regfile_pkg.sv
// Shared pipeline package: datapath geometry and helpers used by every stage register.
package writeback_regfile_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NREG     = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned ZERO_REG = 0;
    localparam int unsigned COUNT_W  = 32;

    typedef logic [COUNT_W-1:0] count_t;

    // Saturating increment: the commit counter holds at all-ones.
    function automatic count_t satInc(input count_t value);
        return (value == '1) ? value : value + count_t'(1);
    endfunction

endpackage

// File: rtl/writeback_regfile_if.sv
// MEM/WB write-back and decode read-port bundle between the pipeline and the register file.
interface writeback_regfile_if #(
    parameter int unsigned DATA_W = writeback_regfile_pkg::DATA_W,
    parameter int unsigned ADDR_W = writeback_regfile_pkg::ADDR_W
) ();

    logic              RegWrite_WB;
    logic              MemtoReg_WB;
    logic [DATA_W-1:0] readMem_WB;
    logic [DATA_W-1:0] ALUResult_WB;
    logic [ADDR_W-1:0] WriteReg_WB;
    logic [ADDR_W-1:0] ReadReg1;
    logic [ADDR_W-1:0] ReadReg2;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;
    logic [DATA_W-1:0] WriteData_WB;
    logic [31:0]       WriteCount;

    modport master (
        output RegWrite_WB, MemtoReg_WB, readMem_WB, ALUResult_WB, WriteReg_WB,
        output ReadReg1, ReadReg2,
        input  ReadData1, ReadData2, WriteData_WB, WriteCount
    );

    modport slave (
        input  RegWrite_WB, MemtoReg_WB, readMem_WB, ALUResult_WB, WriteReg_WB,
        input  ReadReg1, ReadReg2,
        output ReadData1, ReadData2, WriteData_WB, WriteCount
    );

endinterface

// File: rtl/writeback_regfile_wb_mux.sv
// Write-back source select: memory read data or ALU result.
module wb_mux #(
    parameter int unsigned DATA_W = writeback_regfile_pkg::DATA_W
) (
    input  logic              memtoReg,
    input  logic [DATA_W-1:0] readMem,
    input  logic [DATA_W-1:0] aluResult,
    output logic [DATA_W-1:0] writeData
);

    assign writeData = memtoReg ? readMem : aluResult;

endmodule

// File: rtl/writeback_regfile.sv
// Flip-flop register file with write-before-read bypass and a saturating commit counter.
module writeback_regfile #(
    parameter int unsigned DATA_W = writeback_regfile_pkg::DATA_W,
    parameter int unsigned NREG   = writeback_regfile_pkg::NREG,
    parameter int unsigned ADDR_W = writeback_regfile_pkg::ADDR_W
) (
    input logic                Clk,
    input logic                Reset_n,
    writeback_regfile_if.slave bus
);

    import writeback_regfile_pkg::*;

    logic [DATA_W-1:0] regsQ [NREG];
    logic [DATA_W-1:0] writeData;
    logic              commit;
    count_t            writeCountQ;
    count_t            writeCountD;

    wb_mux #(
        .DATA_W (DATA_W)
    ) uWbMux (
        .memtoReg  (bus.MemtoReg_WB),
        .readMem   (bus.readMem_WB),
        .aluResult (bus.ALUResult_WB),
        .writeData (writeData)
    );

    assign commit = bus.RegWrite_WB && (bus.WriteReg_WB != ADDR_W'(ZERO_REG));

    function automatic logic [DATA_W-1:0] readPort(input logic [ADDR_W-1:0] idx);
        if (idx == ADDR_W'(ZERO_REG)) begin
            return '0;
        end else if (bus.RegWrite_WB && (bus.WriteReg_WB == idx)) begin
            return writeData;
        end else begin
            return regsQ[idx];
        end
    endfunction

    always_comb begin
        bus.ReadData1    = readPort(bus.ReadReg1);
        bus.ReadData2    = readPort(bus.ReadReg2);
        bus.WriteData_WB = writeData;
        bus.WriteCount   = writeCountQ;
        writeCountD      = commit ? satInc(writeCountQ) : writeCountQ;
    end

    // Reset wins over a same-edge commit; every entry clears in one edge.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regsQ[i] <= '0;
            end
            writeCountQ <= '0;
        end else begin
            if (commit) begin
                regsQ[bus.WriteReg_WB] <= writeData;
            end
            writeCountQ <= writeCountD;
        end
    end

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: per-cycle model comparison plus literal checks.
module tb_writeback_regfile;

    logic Clk;
    logic Reset_n;
    logic checkEn;
    logic preloadPulse;
    int   total;
    int   bad;

    writeback_regfile_if bus ();

    writeback_regfile dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Behavioural model: architectural register contents and commit count.
    logic [31:0] modelMem [32];
    logic [31:0] modelCount;

    initial begin
        for (int i = 0; i < 32; i++) modelMem[i] = 32'h0;
        modelCount = 32'h0;
    end

    function automatic logic [31:0] expWd();
        return bus.MemtoReg_WB ? bus.readMem_WB : bus.ALUResult_WB;
    endfunction

    function automatic logic [31:0] expRead(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
        if (bus.RegWrite_WB && bus.WriteReg_WB == idx) return expWd();
        return modelMem[idx];
    endfunction

    always @(posedge Clk or posedge preloadPulse) begin
        if (preloadPulse) begin
            modelCount <= 32'hFFFF_FFFE;
        end else if (!Reset_n) begin
            for (int i = 0; i < 32; i++) modelMem[i] <= 32'h0;
            modelCount <= 32'h0;
        end else if (bus.RegWrite_WB && bus.WriteReg_WB != 5'd0) begin
            modelMem[bus.WriteReg_WB] <= expWd();
            modelCount <= (modelCount == 32'hFFFF_FFFF) ? modelCount : modelCount + 32'd1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (checkEn) begin
            check("model ReadData1", bus.ReadData1, expRead(bus.ReadReg1));
            check("model ReadData2", bus.ReadData2, expRead(bus.ReadReg2));
            check("model WriteData_WB", bus.WriteData_WB, expWd());
            check("model WriteCount", bus.WriteCount, modelCount);
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic m2r, input logic [31:0] mem,
                         input logic [31:0] alu, input logic [4:0] wr);
        bus.RegWrite_WB  = we;
        bus.MemtoReg_WB  = m2r;
        bus.readMem_WB   = mem;
        bus.ALUResult_WB = alu;
        bus.WriteReg_WB  = wr;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total        = 0;
        bad          = 0;
        checkEn      = 1'b0;
        preloadPulse = 1'b0;
        Reset_n      = 1'b0;
        bus.ReadReg1 = 5'd0;
        bus.ReadReg2 = 5'd0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);

        // Reset: every index reads 0, counter 0.
        tick();
        Reset_n = 1'b1;
        checkEn = 1'b1;
        for (int i = 0; i < 32; i++) begin
            bus.ReadReg1 = 5'(i);
            bus.ReadReg2 = 5'(31 - i);
            #1;
            check("reset ReadData1", bus.ReadData1, 32'h0);
            check("reset ReadData2", bus.ReadData2, 32'h0);
        end
        check("reset WriteCount", bus.WriteCount, 32'h0);

        // Basic write then read from storage.
        drive(1'b1, 1'b0, 32'h0, 32'h0000_1234, 5'd5);
        bus.ReadReg1 = 5'd5;
        tick();
        bus.RegWrite_WB = 1'b0;
        #1;
        check("write5 ReadData1", bus.ReadData1, 32'h0000_1234);
        check("write5 WriteCount", bus.WriteCount, 32'd1);

        // Same-cycle bypass from memory data.
        drive(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_1111, 5'd7);
        bus.ReadReg2 = 5'd7;
        #1;
        check("bypass ReadData2", bus.ReadData2, 32'hDEAD_BEEF);
        check("bypass WriteData_WB", bus.WriteData_WB, 32'hDEAD_BEEF);
        tick();
        bus.RegWrite_WB = 1'b0;
        #1;
        check("stored7 ReadData2", bus.ReadData2, 32'hDEAD_BEEF);
        check("stored7 WriteCount", bus.WriteCount, 32'd2);

        // Register 0 write is discarded.
        drive(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 5'd0);
        bus.ReadReg1 = 5'd0;
        #1;
        check("zero pre ReadData1", bus.ReadData1, 32'h0);
        tick();
        check("zero post ReadData1", bus.ReadData1, 32'h0);
        check("zero WriteCount", bus.WriteCount, 32'd2);

        // Fill every register, alternating source.
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 1'(i % 2), 32'hA000_0000 | 32'(i), 32'h0B00_0000 + 32'(i * 3), 5'(i));
            bus.ReadReg1 = 5'(i);
            bus.ReadReg2 = 5'(31 - i);
            tick();
        end
        bus.RegWrite_WB = 1'b0;
        for (int i = 0; i < 32; i++) begin
            bus.ReadReg1 = 5'(i);
            bus.ReadReg2 = 5'(i);
            #2;
            check("same-index ports", bus.ReadData2, bus.ReadData1);
        end
        bus.ReadReg1 = 5'd10;
        bus.ReadReg2 = 5'd7;
        #1;
        check("fill reg10", bus.ReadData1, 32'h0B00_001E);
        check("fill reg7", bus.ReadData2, 32'hA000_0007);
        check("fill WriteCount", bus.WriteCount, 32'd33);

        // Disabled write leaves state untouched.
        drive(1'b0, 1'b0, 32'h0, 32'hDEAD_0000, 5'd10);
        tick();
        check("nowrite reg10", bus.ReadData1, 32'h0B00_001E);
        check("nowrite WriteCount", bus.WriteCount, 32'd33);

        // Reset beats a same-edge commit; bypass stays live during reset.
        Reset_n = 1'b0;
        drive(1'b1, 1'b0, 32'h0, 32'h0000_0055, 5'd3);
        bus.ReadReg1 = 5'd3;
        bus.ReadReg2 = 5'd10;
        #1;
        check("reset bypass ReadData1", bus.ReadData1, 32'h0000_0055);
        tick();
        Reset_n = 1'b1;
        bus.RegWrite_WB = 1'b0;
        #1;
        check("reset-vs-write reg3", bus.ReadData1, 32'h0);
        check("reset clears reg10", bus.ReadData2, 32'h0);
        check("reset-vs-write WriteCount", bus.WriteCount, 32'h0);

        // Saturation via backdoor preload of the counter.
        force dut.writeCountQ = 32'hFFFF_FFFE;
        preloadPulse = 1'b1;
        #1;
        preloadPulse = 1'b0;
        release dut.writeCountQ;
        drive(1'b1, 1'b0, 32'h0, 32'h0000_0042, 5'd4);
        tick();
        check("sat first WriteCount", bus.WriteCount, 32'hFFFF_FFFF);
        tick();
        check("sat hold WriteCount", bus.WriteCount, 32'hFFFF_FFFF);
        bus.RegWrite_WB = 1'b0;
        tick();

        checkEn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register and datapath width in bits.
REQ-002 The block SHALL have parameter NREG, default 32, meaning number of architectural registers.
REQ-003 The block SHALL have parameter ADDR_W, default 5, meaning register index width (log2 NREG).
REQ-004 Clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Reset_n  input  1  reset, synchronous, active-low.
REQ-006 RegWrite_WB  input  1  write-back enable from the MEM/WB stage.
REQ-007 MemtoReg_WB  input  1  write-back source select: 1 = memory read data, 0 = ALU result.
REQ-008 readMem_WB  input  DATA_W  data-memory read value from MEM/WB.
REQ-009 ALUResult_WB  input  DATA_W  ALU result from MEM/WB.
REQ-010 WriteReg_WB  input  ADDR_W  destination register index from MEM/WB.
REQ-011 ReadReg1, ReadReg2  input  ADDR_W each  decode-stage source register indices.
REQ-012 ReadData1, ReadData2  output  DATA_W each  decode-stage source operands.
REQ-013 WriteData_WB  output  DATA_W  selected write-back value, exported for forwarding.
REQ-014 WriteCount  output  32  number of committed register writes since reset.

Function
REQ-015 WriteData_WB SHALL equal readMem_WB when MemtoReg_WB=1, else ALUResult_WB, combinationally.
REQ-016 A commit SHALL occur on a rising Clk edge when Reset_n=1, RegWrite_WB=1 and WriteReg_WB!=0; register[WriteReg_WB] takes WriteData_WB.
REQ-017 Writes with WriteReg_WB=0 SHALL be discarded; register 0 SHALL read 0 always.
REQ-018 ReadDataN SHALL be combinational: 0 if ReadRegN=0; else WriteData_WB if RegWrite_WB=1 and WriteReg_WB=ReadRegN (write-before-read bypass); else stored register[ReadRegN].
REQ-019 Both read ports SHALL be independent; identical indices on both ports SHALL return identical values.
REQ-020 WriteCount SHALL increment by 1 per commit (REQ-016 only), saturating at 32'hFFFFFFFF.
REQ-021 Write latency SHALL be zero cycles to the read ports (via bypass) and one edge to storage.
REQ-022 RegWrite_WB=0 SHALL leave all state unchanged regardless of other inputs.

Reset
REQ-023 On a rising Clk edge with Reset_n=0, all registers and WriteCount SHALL become 0.
REQ-024 Reset SHALL take priority over a simultaneous commit; that commit is lost and not counted.
REQ-025 While Reset_n=0, ReadDataN SHALL still follow REQ-018 (bypass remains combinational); stored values read 0 after the first reset edge.
REQ-026 Reset asserted mid-stream SHALL discard all prior contents; no partial state survives.

Structure
REQ-027 DATA_W, ADDR_W, NREG and ZERO_REG (=0) SHALL live in the shared pipeline package used by all pipeline-stage registers.
REQ-028 The MemtoReg selection SHALL be one sub-module, wb_mux, instantiated once; storage, bypass and counter stay in writeback_regfile.
REQ-029 Storage SHALL be a flip-flop array (no inferred RAM) so reset clears every entry in one edge.

Verification
REQ-030 Reset: hold Reset_n=0 one edge, RegWrite_WB=0 -> ReadData1/2=0 for indices 0..31, WriteCount=0.
REQ-031 Write/read: RegWrite_WB=1, MemtoReg_WB=0, ALUResult_WB=32'h0000_1234, WriteReg_WB=5, one edge, then RegWrite_WB=0, ReadReg1=5 -> ReadData1=32'h0000_1234, WriteCount=1.
REQ-032 Bypass: RegWrite_WB=1, MemtoReg_WB=1, readMem_WB=32'hDEAD_BEEF, WriteReg_WB=7, ReadReg2=7 before edge -> ReadData2=32'hDEAD_BEEF same cycle; after edge with RegWrite_WB=0 still 32'hDEAD_BEEF.
REQ-033 Zero register: RegWrite_WB=1, WriteReg_WB=0, ALUResult_WB=32'hFFFF_FFFF, ReadReg1=0 -> ReadData1=0 before and after edge, WriteCount unchanged.
REQ-034 Reset vs write: Reset_n=0 and RegWrite_WB=1, WriteReg_WB=3, ALUResult_WB=32'h55 same edge -> register 3 reads 0 afterwards, WriteCount=0.
REQ-035 Saturation: force 2^32-1 commits (or preload via backdoor) then one more commit -> WriteCount stays 32'hFFFFFFFF.
